// File: rtl/imem_fetch_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : imem_fetch_arbiter
// Description : Round-robin arbiter sharing a byte-wide combinational-read
//               memory between an instruction-fetch port (I) and a data/debug
//               port (D). Each grant performs four byte reads and returns a
//               big-endian 32-bit word with a one-cycle valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int ADDR_MAX = 100
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic              IValid,
  output logic [31:0]       IData,
  output logic              IErr,
  input  logic              DReq,
  input  logic [ADDR_W-1:0] DAddr,
  output logic              DValid,
  output logic [31:0]       DData,
  output logic              DErr,
  output logic [ADDR_W-1:0] MAddr,
  output logic              MRW,
  input  logic [7:0]        MByte,
  output logic              Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                last_gnt_q, last_gnt_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                err_q, err_d;
  logic [31:0]         word_q, word_d;
  logic [31:0]         idata_q, idata_d;
  logic                ierr_q, ierr_d;
  logic [31:0]         ddata_q, ddata_d;
  logic                derr_q, derr_d;

  logic                gnt_port;
  logic [ADDR_W-1:0]   sel_addr;
  logic [ADDR_W:0]     sel_end;
  logic                sel_err;
  logic [31:0]         next_word;

  // Grant selection and legality check for the request seen in IDLE; the
  // end address is computed one bit wider so a high base cannot wrap to legal.
  always_comb begin
    if (IReq && DReq) begin
      gnt_port = ~last_gnt_q;
    end else if (IReq) begin
      gnt_port = PORT_I;
    end else begin
      gnt_port = PORT_D;
    end
    sel_addr  = (gnt_port == PORT_D) ? DAddr : IAddr;
    sel_end   = {1'b0, sel_addr} + (ADDR_W+1)'(3);
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_end > (ADDR_W+1)'(ADDR_MAX));
    next_word = {word_q[23:0], MByte};
  end

  // Next-state logic; result registers are loaded on the edge that enters RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    base_d     = base_q;
    err_d      = err_q;
    word_d     = word_q;
    idata_d    = idata_q;
    ierr_d     = ierr_q;
    ddata_d    = ddata_q;
    derr_d     = derr_q;
    case (state_q)
      IDLE: begin
        if (IReq || DReq) begin
          owner_d    = gnt_port;
          last_gnt_d = gnt_port;
          base_d     = sel_addr;
          err_d      = sel_err;
          cnt_d      = 2'd0;
          word_d     = 32'h0;
          if (sel_err) begin
            state_d = RESP;
            if (gnt_port == PORT_I) begin
              idata_d = 32'h0;
              ierr_d  = 1'b1;
            end else begin
              ddata_d = 32'h0;
              derr_d  = 1'b1;
            end
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        word_d = next_word;
        if (cnt_q == 2'd3) begin
          state_d = RESP;
          if (owner_q == PORT_I) begin
            idata_d = next_word;
            ierr_d  = 1'b0;
          end else begin
            ddata_d = next_word;
            derr_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      last_gnt_q <= PORT_D;
      owner_q    <= PORT_I;
      base_q     <= '0;
      err_q      <= 1'b0;
      word_q     <= 32'h0;
      idata_q    <= 32'h0;
      ierr_q     <= 1'b0;
      ddata_q    <= 32'h0;
      derr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      base_q     <= base_d;
      err_q      <= err_d;
      word_q     <= word_d;
      idata_q    <= idata_d;
      ierr_q     <= ierr_d;
      ddata_q    <= ddata_d;
      derr_q     <= derr_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    IValid = (state_q == RESP) && (owner_q == PORT_I);
    DValid = (state_q == RESP) && (owner_q == PORT_D);
    IData  = idata_q;
    IErr   = ierr_q;
    DData  = ddata_q;
    DErr   = derr_q;
    MRW    = (state_q == READ);
    MAddr  = MRW ? (base_q + ADDR_W'(cnt_q)) : '0;
    Busy   = (state_q != IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_imem_fetch_arbiter
// Description : Scoreboard bench for imem_fetch_arbiter with a byte memory
//               model; expected words are queued per port at request time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_arbiter;

  localparam int ADDR_W   = 32;
  localparam int ADDR_MAX = 100;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              IReq = 1'b0;
  logic [ADDR_W-1:0] IAddr = '0;
  logic              IValid;
  logic [31:0]       IData;
  logic              IErr;
  logic              DReq = 1'b0;
  logic [ADDR_W-1:0] DAddr = '0;
  logic              DValid;
  logic [31:0]       DData;
  logic              DErr;
  logic [ADDR_W-1:0] MAddr;
  logic              MRW;
  logic [7:0]        MByte;
  logic              Busy;

  imem_fetch_arbiter #(.ADDR_W(ADDR_W), .ADDR_MAX(ADDR_MAX)) dut (
    .CLK(CLK), .RST(RST),
    .IReq(IReq), .IAddr(IAddr), .IValid(IValid), .IData(IData), .IErr(IErr),
    .DReq(DReq), .DAddr(DAddr), .DValid(DValid), .DData(DData), .DErr(DErr),
    .MAddr(MAddr), .MRW(MRW), .MByte(MByte), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // Byte memory model: combinational read, undriven when not enabled.
  logic [7:0] mem [0:127];
  assign MByte = MRW ? mem[MAddr[6:0]] : 8'hzz;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_i[$];
  exp_t exp_d[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model of one word request.
  function automatic exp_t model(input logic [31:0] a);
    exp_t        r;
    logic [32:0] e;
    logic [6:0]  b;
    e = {1'b0, a} + 33'd3;
    b = a[6:0];
    if (a[1:0] != 2'b00 || e > 33'(ADDR_MAX)) begin
      r.data = 32'h0;
      r.err  = 1'b1;
    end else begin
      r.data = {mem[b], mem[b + 7'd1], mem[b + 7'd2], mem[b + 7'd3]};
      r.err  = 1'b0;
    end
    return r;
  endfunction

  // Scoreboard monitor: every valid pulse pops and checks its port's queue.
  always @(negedge CLK) begin
    exp_t e;
    if (mon_en) begin
      if (IValid) begin
        chk("i_expected", 32'(exp_i.size() > 0), 32'd1);
        if (exp_i.size() > 0) begin
          e = exp_i.pop_front();
          chk("idata", IData, e.data);
          chk("ierr", 32'(IErr), 32'(e.err));
        end
      end
      if (DValid) begin
        chk("d_expected", 32'(exp_d.size() > 0), 32'd1);
        if (exp_d.size() > 0) begin
          e = exp_d.pop_front();
          chk("ddata", DData, e.data);
          chk("derr", 32'(DErr), 32'(e.err));
        end
      end
      if (IValid || DValid) chk("single_valid", 32'(IValid & DValid), 32'd0);
    end
  end

  task automatic apply_reset();
    RST  = 1'b0;
    IReq = 1'b0;
    DReq = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_flags", {26'b0, IValid, DValid, IErr, DErr, MRW, Busy}, 32'd0);
    chk("rst_idata", IData, 32'd0);
    chk("rst_ddata", DData, 32'd0);
    chk("rst_maddr", MAddr, 32'd0);
    exp_i.delete();
    exp_d.delete();
    RST = 1'b1;
    @(negedge CLK);
  endtask

  // One request on a single port; checks address sequence and latency.
  task automatic do_req(input bit port, input logic [31:0] addr);
    exp_t e;
    int   cyc;
    int   nrd;
    bit   got;
    e = model(addr);
    if (port) begin
      DAddr = addr;
      DReq  = 1'b1;
      exp_d.push_back(e);
    end else begin
      IAddr = addr;
      IReq  = 1'b1;
      exp_i.push_back(e);
    end
    cyc = 0;
    nrd = 0;
    got = 1'b0;
    while (!got && cyc < 30) begin
      @(negedge CLK);
      cyc++;
      if (MRW) begin
        chk("maddr_step", MAddr, addr + 32'(nrd));
        nrd++;
      end
      if (port ? DValid : IValid) got = 1'b1;
    end
    chk("valid_seen", 32'(got), 32'd1);
    chk("latency", 32'(cyc), e.err ? 32'd1 : 32'd5);
    chk("mrw_cycles", 32'(nrd), e.err ? 32'd0 : 32'd4);
    IReq = 1'b0;
    DReq = 1'b0;
    @(negedge CLK);
    chk("idle_after", 32'(Busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t_i[$];
    int t_d[$];
    for (int i = 0; i < 128; i++) mem[i] = 8'((i * 7) + 8'h31);
    mem[0] = 8'h8C; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h04;
    mem[4] = 8'h20; mem[5] = 8'h02; mem[6] = 8'h00; mem[7] = 8'h05;
    mon_en = 1'b1;
    apply_reset();

    // Single-port legal reads.
    do_req(1'b0, 32'd0);
    chk("idata_word0", IData, 32'h8C010004);
    do_req(1'b1, 32'd4);
    chk("ddata_word4", DData, 32'h20020005);
    chk("idata_held", IData, 32'h8C010004);

    // Both requests held from reset: strict alternation I, D, I.
    apply_reset();
    exp_i.push_back(model(32'd0));
    exp_d.push_back(model(32'd4));
    exp_i.push_back(model(32'd0));
    IAddr = 32'd0;
    DAddr = 32'd4;
    IReq  = 1'b1;
    DReq  = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge CLK);
      if (IValid) t_i.push_back(c);
      if (DValid) t_d.push_back(c);
    end
    IReq = 1'b0;
    DReq = 1'b0;
    @(negedge CLK);
    chk("rr_i_count", 32'(t_i.size()), 32'd2);
    chk("rr_d_count", 32'(t_d.size()), 32'd1);
    chk("rr_i_first", 32'(t_i.size() > 0 ? t_i[0] : -1), 32'd5);
    chk("rr_d_first", 32'(t_d.size() > 0 ? t_d[0] : -1), 32'd11);
    chk("rr_i_second", 32'(t_i.size() > 1 ? t_i[1] : -1), 32'd17);

    // Error and boundary addresses.
    do_req(1'b0, 32'd2);
    chk("idata_err_zero", IData, 32'd0);
    do_req(1'b0, 32'd100);
    do_req(1'b0, 32'd96);
    do_req(1'b0, 32'hFFFF_FFFC);
    do_req(1'b1, 32'd97);
    do_req(1'b1, 32'd8);

    // Reset mid-READ aborts with no valid pulse.
    IAddr = 32'd0;
    IReq  = 1'b1;
    repeat (3) @(negedge CLK);
    chk("mid_maddr", MAddr, 32'd2);
    chk("mid_mrw", 32'(MRW), 32'd1);
    RST = 1'b0;
    #1;
    chk("abort_mrw", 32'(MRW), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    IReq = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    do_req(1'b0, 32'd0);
    chk("idata_after_abort", IData, 32'h8C010004);

    repeat (3) @(negedge CLK);
    chk("i_queue_empty", 32'(exp_i.size()), 32'd0);
    chk("d_queue_empty", 32'(exp_d.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_fetch_arbiter.md
Name: imem_fetch_arbiter

Overview:
- Shares one byte-wide instruction/constant memory between two word requesters: the instruction-fetch port (I) and a data/debug read port (D).
- The memory is byte-addressed, read-only with combinational read, and gated by a read-enable RW. When RW=0 it drives z.
- For each granted request the block issues 4 sequential byte reads, assembles a big-endian 32-bit word (byte at base address -> bits [31:24]), and returns it with a one-cycle valid pulse.
- Sits between the multi-cycle CPU control unit and the memory.

Parameters:
- ADDR_W, 32, address width of requester and memory address ports.
- ADDR_MAX, 100, highest valid byte address. A word request is legal only if base+3 <= ADDR_MAX.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous active-low reset.
- IReq  input  1  fetch-port request. Held high until IValid.
- IAddr  input  ADDR_W  fetch-port byte address of the word.
- IValid  output  1  one-cycle pulse: IData/IErr valid.
- IData  output  32  fetch-port read word.
- IErr  output  1  fetch-port error. Qualified by IValid.
- DReq  input  1  data-port request. Held high until DValid.
- DAddr  input  ADDR_W  data-port byte address.
- DValid  output  1  one-cycle pulse: DData/DErr valid.
- DData  output  32  data-port read word.
- DErr  output  1  data-port error. Qualified by DValid.
- MAddr  output  ADDR_W  memory byte address.
- MRW  output  1  memory read enable (1 = drive byte).
- MByte  input  8  memory read byte, combinational from MAddr/MRW.
- Busy  output  1  high when not in IDLE.

Behaviour:
- Reset (RST=0, async):
  - State goes to IDLE, byte counter to 0, LastGnt to D, so the first tie goes to I.
  - IValid, DValid, IErr, DErr, MRW, Busy are all 0.
  - IData, DData, MAddr are all 0.
- States: IDLE, READ, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If only one request is high, grant it.
  - If both are high, grant the port not equal to LastGnt (round-robin).
  - On grant: latch base address, owner, and error check. Update LastGnt := owner.
  - Error check: base[1:0] != 0, or base+3 > ADDR_MAX (compute in ADDR_W+1 bits so there is no wrap).
  - If error: go to RESP with err flag set, skip READ.
  - Else: go to READ with counter=0 and the assembly register cleared.
- READ (4 cycles, counter 0..3):
  - MRW=1 and MAddr=base+counter, driven combinationally from registered state.
  - At each rising edge, shift MByte into the assembly register: word = {word[23:0], MByte}.
  - When counter=3, go to RESP. Otherwise counter+1.
- RESP (1 cycle):
  - Owner's Valid=1, its Data = assembled word (0 on error), its Err = error flag.
  - The other port's Valid=0.
  - Next state is IDLE.
  - Data/Err outputs hold their value until the owner's next RESP.
- MRW=0 and MAddr=0 in IDLE and RESP.
- Latency from request sampled in IDLE to Valid:
  - 5 cycles for a legal access (grant edge, 4 read edges).
  - 1 cycle for an error.
- Throughput: one word per 6 cycles.
- Requests are sampled only in IDLE.
- A request dropped mid-transaction is a protocol violation. The transaction still completes and Valid still pulses.
- A request still high in the cycle after its Valid is treated as a new request.
- Address changes after grant are ignored. The base address is latched.
- Simultaneous requests: strict alternation when both stay asserted, giving sequence I, D, I, D.
- Reset asserted mid-READ aborts immediately:
  - MRW drops asynchronously.
  - No Valid is issued for the aborted transaction.
  - After release, the block restarts in IDLE.
- Busy = (state != IDLE).

Test Plan:
- Memory preloaded: bytes 0..7 = 8C,01,00,04,20,02,00,05. IReq=1, IAddr=0 -> MAddr steps 0,1,2,3 with MRW=1 over 4 cycles. IValid pulses 5 cycles after the request with IData=32'h8C010004, IErr=0.
- DReq=1, DAddr=4 alone -> DValid after 5 cycles, DData=32'h20020005, IValid stays 0.
- IReq and DReq both held from reset (IAddr=0, DAddr=4) -> grant order I, D, I. Valid pulses at cycles 5, 11, 17 with the correct words.
- IAddr=2 (misaligned) -> IValid on the next cycle with IErr=1, IData=0, MRW never high. IAddr=100 (ADDR_MAX=100) -> IErr=1.
- IAddr=96 -> legal, reads bytes 96..99. IAddr=32'hFFFFFFFC -> IErr=1, no address wrap.
- RST pulled low while counter=2 -> MRW=0 and Busy=0 immediately, no IValid. After release, a fresh IReq at IAddr=0 returns 32'h8C010004.
